// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: controller state encoding
// and helpers that size the chunk counter from the operand/slice widths.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slices needed to cover one operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; at least one bit even for a single-slice run.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/ripple_slice.sv
// CHUNK-bit combinational ripple adder reused once per cycle by the serial
// adder. Also exposes the carry into its top bit so the caller can derive
// signed overflow on the most significant slice.
module ripple_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_c;

    // Bit-by-bit ripple of the carry through the slice.
    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, with
// valid/ready handshakes on both sides and fully registered outputs.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IW     = calc_idx_w(NCHUNK);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("chunked_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CHUNK-1:0]       w_sl_sum;
    logic                   w_sl_cout;
    logic                   w_sl_cmsb;
    logic [WIDTH+CHUNK-1:0] w_sum_cat;
    logic [WIDTH-1:0]       w_sum_shift;

    ripple_slice #(.CHUNK(CHUNK)) u_slice (
        .a        (r_a[CHUNK-1:0]),
        .b        (r_b[CHUNK-1:0]),
        .cin      (r_carry),
        .sum      (w_sl_sum),
        .cout     (w_sl_cout),
        .c_msb_in (w_sl_cmsb)
    );

    // Concatenate-then-select keeps the shift legal when CHUNK == WIDTH.
    assign w_sum_cat   = {w_sl_sum, r_sum};
    assign w_sum_shift = w_sum_cat[WIDTH+CHUNK-1:CHUNK];

    // Controller and datapath: capture, per-slice accumulate, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_shift;
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_sl_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_cout      <= w_sl_cout;
                        r_ovf       <= w_sl_cout ^ w_sl_cmsb;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder at CHUNK = 4, 1 and 16
// (WIDTH = 16). A per-cycle arithmetic model checks all three instances;
// directed operations pin literal results and latencies.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] a         [3];
    logic [15:0] b         [3];
    logic        cin       [3];
    logic        sub       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] sum       [3];
    logic        cout      [3];
    logic        ovf       [3];

    int NCH [3] = '{4, 16, 1};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_ready [3] = '{1'b1, 1'b1, 1'b1};
    logic        m_valid [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_run   [3] = '{1'b0, 1'b0, 1'b0};
    int          m_cnt   [3] = '{0, 0, 0};
    logic [15:0] m_sum   [3] = '{16'h0, 16'h0, 16'h0};
    logic        m_cout  [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_ovf   [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] p_sum   [3];
    logic        p_cout  [3];
    logic        p_ovf   [3];

    // Outputs are checked at negedge; the model then steps for the coming posedge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("mdl_out_valid", k, 32'(out_valid[k]), 32'(m_valid[k]));
            chk("mdl_in_ready",  k, 32'(in_ready[k]),  32'(m_ready[k]));
            if (!m_run[k]) begin
                chk("mdl_sum",  k, 32'(sum[k]),  32'(m_sum[k]));
                chk("mdl_cout", k, 32'(cout[k]), 32'(m_cout[k]));
                chk("mdl_ovf",  k, 32'(ovf[k]),  32'(m_ovf[k]));
            end
            if (rst) begin
                m_ready[k] = 1'b1; m_valid[k] = 1'b0; m_run[k] = 1'b0;
                m_sum[k] = 16'h0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
            end else if (m_ready[k]) begin
                if (in_valid[k]) begin
                    logic [15:0] eb;
                    logic [16:0] full;
                    eb   = sub[k] ? ~b[k] : b[k];
                    full = {1'b0, a[k]} + {1'b0, eb} + 17'(sub[k] ? 1'b1 : cin[k]);
                    p_sum[k]  = full[15:0];
                    p_cout[k] = full[16];
                    p_ovf[k]  = (a[k][15] == eb[15]) && (full[15] != a[k][15]);
                    m_ready[k] = 1'b0;
                    m_run[k]   = 1'b1;
                    m_cnt[k]   = NCH[k];
                end
            end else if (m_run[k]) begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    m_run[k]   = 1'b0;
                    m_valid[k] = 1'b1;
                    m_sum[k]   = p_sum[k];
                    m_cout[k]  = p_cout[k];
                    m_ovf[k]   = p_ovf[k];
                end
            end else if (m_valid[k] && out_ready[k]) begin
                m_valid[k] = 1'b0;
                m_ready[k] = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input int k, input logic [15:0] ai, input logic [15:0] bi,
                          input logic ci, input logic si, input logic [15:0] es,
                          input logic ec, input logic eo, input int lat, input string nm);
        int n;
        chk({nm, "_ready_before"}, k, 32'(in_ready[k]), 32'd1);
        a[k] = ai; b[k] = bi; cin[k] = ci; sub[k] = si;
        in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        a[k] = 16'($urandom); b[k] = 16'($urandom);
        cin[k] = 1'($urandom); sub[k] = 1'($urandom);
        n = 0;
        while (!out_valid[k] && n < 40) begin
            chk({nm, "_ready_busy"}, k, 32'(in_ready[k]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, k, 32'(n), 32'(lat));
        chk({nm, "_sum"},  k, 32'(sum[k]),  32'(es));
        chk({nm, "_cout"}, k, 32'(cout[k]), 32'(ec));
        chk({nm, "_ovf"},  k, 32'(ovf[k]),  32'(eo));
        chk({nm, "_ready_done"}, k, 32'(in_ready[k]), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid_after"}, k, 32'(out_valid[k]), 32'd0);
        chk({nm, "_ready_after"}, k, 32'(in_ready[k]),  32'd1);
        chk({nm, "_sum_held"},    k, 32'(sum[k]),       32'(es));
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_stream(input int k, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            in_valid[k]  = ($urandom_range(0, 2) != 0);
            a[k]         = pick_operand();
            b[k]         = pick_operand();
            cin[k]       = 1'($urandom);
            sub[k]       = 1'($urandom);
            out_ready[k] = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; a[k] = '0; b[k] = '0;
            cin[k] = 1'b0; sub[k] = 1'b0; out_ready[k] = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready",  k, 32'(in_ready[k]),  32'd1);
            chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            chk("rst_sum",       k, 32'(sum[k]),       32'd0);
            chk("rst_cout",      k, 32'(cout[k]),      32'd0);
            chk("rst_ovf",       k, 32'(ovf[k]),       32'd0);
        end

        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4, "c4_add_basic");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "c4_carry_out");
        run_op(0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, 4, "c4_cin");
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "c4_sub_borrow");
        run_op(0, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 4, "c4_sub_noborrow");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "c4_add_ovf");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "c4_sub_ovf");

        // Backpressure: result must hold while in_valid/a/b wiggle.
        a[0] = 16'h1111; b[0] = 16'h2222; cin[0] = 1'b0; sub[0] = 1'b0;
        out_ready[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 0, 32'(n), 32'd4);
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = ~in_valid[0];
            a[0] = 16'($urandom); b[0] = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_valid_hold", 0, 32'(out_valid[0]), 32'd1);
            chk("bp_ready_low",  0, 32'(in_ready[0]),  32'd0);
            chk("bp_sum_hold",   0, 32'(sum[0]),       32'h3333);
            chk("bp_cout_hold",  0, 32'(cout[0]),      32'd0);
            chk("bp_ovf_hold",   0, 32'(ovf[0]),       32'd0);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("bp_release_ready", 0, 32'(in_ready[0]),  32'd1);
        chk("bp_release_sum",   0, 32'(sum[0]),       32'h3333);

        // Reset asserted while the slice counter is at 2.
        a[0] = 16'h1234; b[0] = 16'h0001; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_ready", 0, 32'(in_ready[0]),  32'd1);
        chk("midrun_rst_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("midrun_rst_sum",   0, 32'(sum[0]),       32'd0);
        run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 4, "c4_after_rst");

        // Bit-serial and single-cycle variants.
        run_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16, "c1_add_basic");
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16, "c1_carry_out");
        run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16, "c1_add_ovf");
        run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16, "c1_sub_ovf");
        run_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1, "c16_add_basic");
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "c16_carry_out");
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, "c16_add_ovf");
        run_op(2, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, "c16_sub_borrow");

        // Random traffic on all three instances, checked by the model.
        fork
            rand_stream(0, 400);
            rand_stream(1, 400);
            rand_stream(2, 400);
        join
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("drain_ready", k, 32'(in_ready[k]),  32'd1);
            chk("drain_valid", k, 32'(out_valid[k]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
